// File: rtl/led_pkg.sv
// led_pkg: shared LED polarity, default PWM sizing and duty type
package led_pkg;
    localparam logic LED_ON  = 1'b0;
    localparam logic LED_OFF = 1'b1;
    localparam int PWM_BITS_DEF = 8;
    localparam int PRESCALE_DEF = 98;
    typedef logic [PWM_BITS_DEF-1:0] duty_t;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: clk prescaler plus free-running PWM counter with tick and wrap strobes
module pwm_timebase #(
    parameter int PRESCALE = 98,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                tick,
    output logic                wrap
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    assign tick = pre == PW'(PRESCALE - 1);
    assign wrap = tick && &pwm_cnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: gated active-low PWM LEDs, duty writes commit at period wrap; LED_PWM_BREATHE_EN ramps channel 0
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(CHANNELS)-1:0] wr_chan,
    input  logic [PWM_BITS-1:0]         wr_duty,
    input  logic [CHANNELS-1:0]         src_in,
    output logic [CHANNELS-1:0]         led,
    output logic                        period_tick
);
    localparam int CW = $clog2(CHANNELS);
    logic [PWM_BITS-1:0] pwm_cnt, pend_duty;
    logic [PWM_BITS-1:0] active_duty [CHANNELS];
    logic [PWM_BITS-1:0] duty [CHANNELS];
    logic [CW-1:0]       pend_chan;
    logic                wrap, pend;
    logic [CHANNELS-1:0] on;

    pwm_timebase #(.PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS)) u_timebase (
        .clk(clk), .reset(reset), .pwm_cnt(pwm_cnt), .tick(), .wrap(wrap)
    );

    // A single pending slot: ready stays low from acceptance until the commit wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ready  <= 1'b0;
            pend      <= 1'b0;
            pend_chan <= '0;
            pend_duty <= '0;
            for (int c = 0; c < CHANNELS; c++) active_duty[c] <= '0;
        end else if (wr_valid && wr_ready) begin
            pend      <= 1'b1;
            pend_chan <= wr_chan;
            pend_duty <= wr_duty;
            wr_ready  <= 1'b0;
        end else if (pend && wrap) begin
            pend     <= 1'b0;
            wr_ready <= 1'b1;
            for (int c = 0; c < CHANNELS; c++)
                if (pend_chan == CW'(c)) active_duty[c] <= pend_duty;
        end else begin
            wr_ready <= !pend;
        end
    end

`ifdef LED_PWM_BREATHE_EN
    logic [PWM_BITS-1:0] ramp;
    logic                up, turn;
    assign turn = up ? &ramp : ramp == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp <= '0;
            up   <= 1'b1;
        end else if (wrap) begin
            up   <= up ^ turn;
            ramp <= (up ^ turn) ? ramp + 1'b1 : ramp - 1'b1;
        end
    end
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) duty[c] = active_duty[c];
        duty[0] = ramp;
    end
`else
    assign duty = active_duty;
`endif

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) on[c] = src_in[c] && (pwm_cnt < duty[c]);
    end

    always_ff @(posedge clk) begin
        period_tick <= !reset && wrap;
        for (int c = 0; c < CHANNELS; c++) led[c] <= (!reset && on[c]) ? LED_ON : LED_OFF;
    end
endmodule
